// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-ported RAM between instruction fetch and data access.
// Each access is one latched command held on the RAM for WAIT_CYCLES+1 cycles, then a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic        last_mem_q, last_mem_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic any_req, pick_mem, last_cycle;

  // Data wins when alone, or when contending and the previous grant went to fetch.
  assign any_req    = if_req | mem_req;
  assign pick_mem   = mem_req & (~if_req | ~last_mem_q);
  assign last_cycle = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (last_cycle) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = 4'h0;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    case (state_q)
      ACCESS: begin
        ram_ce    = 1'b1;
        ram_we    = we_q;
        ram_sel   = sel_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
      end
      RESP: begin
        if_ack  = ~gnt_mem_q;
        mem_ack = gnt_mem_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    gnt_mem_d   = gnt_mem_q;
    last_mem_d  = last_mem_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: if (any_req) begin
        cnt_d      = 4'h0;
        gnt_mem_d  = pick_mem;
        last_mem_d = pick_mem;
        we_d       = pick_mem ? mem_we    : 1'b0;
        sel_d      = pick_mem ? mem_sel   : 4'hF;
        addr_d     = pick_mem ? mem_addr  : if_addr;
        wdata_d    = pick_mem ? mem_wdata : 32'h0;
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'h1;
        if (last_cycle) begin
          if (!gnt_mem_q)  if_inst_d   = ram_rdata;
          else if (!we_q)  mem_rdata_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 4'h0;
      gnt_mem_q   <= 1'b0;
      last_mem_q  <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      cnt_q       <= cnt_d;
      gnt_mem_q   <= gnt_mem_d;
      last_mem_q  <= last_mem_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_inst      = if_inst_q;
  assign mem_rdata    = mem_rdata_q;
  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = mem_req & ~mem_ack;

endmodule
